// File: rtl/instr_seq_ctrl.sv
// Instruction sequencer: host program load into instruction memory,
// then zero-bubble fetch with stall, branch redirect and halt handling.
module instr_seq_ctrl #(
  parameter int          addr_w  = 8,
  parameter int          data_w  = 15,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              ld_valid,
  input  logic [data_w-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              start,
  input  logic [addr_w-1:0] start_addr,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [addr_w-1:0] br_target,
  output logic              mem_we,
  output logic [addr_w-1:0] mem_waddr,
  output logic [data_w-1:0] mem_wdata,
  output logic [addr_w-1:0] mem_raddr,
  input  logic [data_w-1:0] mem_rdata,
  output logic [data_w-1:0] instr,
  output logic              instr_valid,
  output logic [addr_w-1:0] instr_pc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [addr_w:0]   prog_len,
  output logic [15:0]       retired
);

  localparam logic [addr_w-1:0] AMAX  = '1;
  localparam logic [addr_w-1:0] A_ONE = 1;
  localparam logic [addr_w:0]   L_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [addr_w-1:0] wptr_q, wptr_d;
  logic [addr_w-1:0] cur_q, cur_d;
  logic [addr_w:0]   plen_q, plen_d;
  logic [15:0]       ret_q, ret_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [addr_w-1:0] raddr;
  logic              accept;
  logic              rdy;
  logic              vld;
  logic              consume;
  logic              is_halt;

  assign is_halt = (mem_rdata[data_w-1 -: 4] == HALT_OP);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cur_d   = cur_q;
    plen_d  = plen_q;
    ret_d   = ret_q;
    err_d   = err_q;
    done_d  = 1'b0;
    raddr   = cur_q;
    accept  = 1'b0;
    rdy     = 1'b0;
    vld     = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LOAD;
          wptr_d  = '0;
        end else if (start) begin
          state_d = S_RUN;
          raddr   = start_addr;
          cur_d   = start_addr;
          ret_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        rdy = 1'b1;
        if (ld_valid) begin
          accept = 1'b1;
          wptr_d = wptr_q + A_ONE;
          if (ld_last || wptr_q == AMAX) begin
            state_d = S_IDLE;
            plen_d  = {1'b0, wptr_q} + L_ONE;
          end
        end
      end
      S_RUN: begin
        // halt_req masks the presented word so it is never consumed
        vld     = !halt_req;
        consume = vld && !stall;
        if (halt_req) begin
          state_d = S_IDLE;
        end else if (consume) begin
          if (ret_q != 16'hFFFF) ret_d = ret_q + 16'd1;
          if (is_halt) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end else if (br_taken) begin
            raddr = br_target;
            cur_d = br_target;
          end else if (cur_q == AMAX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            raddr = cur_q + A_ONE;
            cur_d = cur_q + A_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      cur_q   <= '0;
      plen_q  <= '0;
      ret_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cur_q   <= cur_d;
      plen_q  <= plen_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // rst also masks the combinational outputs in the reset cycle itself
  assign mem_we      = accept && !rst;
  assign mem_waddr   = wptr_q;
  assign mem_wdata   = ld_data;
  assign mem_raddr   = rst ? '0 : raddr;
  assign ld_ready    = rdy && !rst;
  assign instr       = mem_rdata;
  assign instr_valid = vld && !rst;
  assign instr_pc    = cur_q;
  assign busy        = (state_q != S_IDLE) && !rst;
  assign done        = done_q && !rst;
  assign err         = err_q;
  assign prog_len    = plen_q;
  assign retired     = ret_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Randomized bench for instr_seq_ctrl with an instruction-level
// reference model and a registered-read memory.
module tb_instr_seq_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 15;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_req = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          halt_req = 1'b0;
  logic          stall = 1'b0;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] instr_pc;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   prog_len;
  logic [15:0]   retired;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];

  int total = 0;
  int bad   = 0;
  int exp_len = 0;
  int exp_ret = 0;
  int exp_err = 0;

  instr_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .load_req(load_req), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready),
    .start(start), .start_addr(start_addr),
    .halt_req(halt_req), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .instr_pc(instr_pc),
    .busy(busy), .done(done), .err(err),
    .prog_len(prog_len), .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    load_req = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    start    = 1'b0;
    halt_req = 1'b0;
    stall    = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vld"}, instr_valid, 0);
    chk({tag, "_rdy"}, ld_ready, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_len"}, prog_len, exp_len);
    chk({tag, "_ret"}, retired, exp_ret);
    chk({tag, "_err"}, err, exp_err);
  endtask

  task automatic load(input logic [DW-1:0] w[$],
                      input bit use_last);
    @(negedge clk);
    clr();
    load_req   = 1'b1;
    start      = 1'b1;
    start_addr = 8'h55;
    @(negedge clk);
    clr();
    chk("ld_rdy", ld_ready, 1);
    chk("ld_busy", busy, 1);
    chk("ld_vld", instr_valid, 0);
    for (int i = 0; i < w.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        start    = 1'b1;
        stall    = 1'b1;
        br_taken = 1'b1;
        #1 chk("we_gap", mem_we, 0);
        @(negedge clk);
        clr();
      end
      ld_valid = 1'b1;
      ld_data  = w[i];
      ld_last  = use_last && (i == w.size() - 1);
      #1;
      chk("we", mem_we, 1);
      chk("waddr", mem_waddr, i % DEPTH);
      chk("wdata", mem_wdata, w[i]);
      exp_mem[i % DEPTH] = w[i];
      @(negedge clk);
      clr();
    end
    exp_len = w.size();
    chk_idle("load_end");
  endtask

  task automatic run(input int sa, input int st_pct,
                     input int br_pct, input int st_from,
                     input int st_to, input int br_cyc,
                     input int br_tgt, input int halt_cyc);
    int pc;
    int cyc;
    int e;
    bit fin;
    bit fst;
    @(negedge clk);
    clr();
    start      = 1'b1;
    start_addr = sa[AW-1:0];
    #1 chk("raddr_start", mem_raddr, sa);
    pc      = sa;
    exp_ret = 0;
    exp_err = 0;
    fin     = 1'b0;
    cyc     = 0;
    e       = 0;
    while (!fin) begin
      @(negedge clk);
      clr();
      chk("valid", instr_valid, 1);
      chk("pc", instr_pc, pc);
      chk("instr", instr, exp_mem[pc]);
      chk("ret", retired, exp_ret);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      if (cyc == halt_cyc || cyc >= 3000) begin
        halt_req = 1'b1;
        stall    = $urandom_range(0, 1);
        #1 chk("valid_halt", instr_valid, 0);
        @(negedge clk);
        clr();
        chk("halt_done", done, 0);
        chk_idle("halt");
        fin = 1'b1;
      end else begin
        fst       = (cyc >= st_from && cyc <= st_to);
        stall     = fst || ($urandom_range(0, 99) < st_pct);
        br_taken  = fst || (cyc == br_cyc) ||
                    ($urandom_range(0, 99) < br_pct);
        br_target = (cyc == br_cyc) ? br_tgt[AW-1:0]
                                    : AW'($urandom_range(0, DEPTH-1));
        load_req  = $urandom_range(0, 1);
        start     = $urandom_range(0, 1);
        if (!stall) begin
          if (exp_ret < 65535) exp_ret++;
          if (exp_mem[pc][DW-1 -: 4] == 4'hF) begin
            fin = 1'b1;
            e   = 0;
          end else if (br_taken) begin
            pc = int'(br_target);
          end else if (pc == DEPTH - 1) begin
            fin = 1'b1;
            e   = 1;
          end else begin
            pc++;
          end
        end
        if (fin) begin
          @(negedge clk);
          clr();
          exp_err = e;
          chk("done", done, 1);
          chk_idle("end");
          @(negedge clk);
          chk("done_pulse", done, 0);
          chk_idle("after");
        end
      end
      cyc++;
    end
  endtask

  initial begin
    logic [DW-1:0] q[$];
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    rst      = 1'b1;
    load_req = 1'b1;
    start    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_raddr", mem_raddr, 0);
    chk_idle("rst");
    chk("rst_done", done, 0);
    chk("rst_pc", instr_pc, 0);
    rst = 1'b0;
    clr();
    @(negedge clk);
    chk("post_rst_raddr", mem_raddr, 0);
    chk_idle("post_rst");

    q = {15'h0001, 15'h0002, 15'h0003, 15'h7800};
    load(q, 1'b1);
    run(0, 0, 0, -1, -1, -1, 0, -1);
    run(0, 0, 0, 1, 3, -1, 0, -1);
    run(0, 0, 0, -1, -1, 1, 32, -1);

    @(negedge clk);
    clr();
    load_req = 1'b1;
    @(negedge clk);
    clr();
    ld_valid = 1'b1;
    ld_data  = 15'h1234;
    #1 chk("we_pre_rst", mem_we, 1);
    exp_mem[0] = 15'h1234;
    @(negedge clk);
    clr();
    rst      = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 15'h0BAD;
    #1;
    chk("we_in_rst", mem_we, 0);
    chk("rdy_in_rst", ld_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    clr();
    exp_len = 0;
    exp_ret = 0;
    exp_err = 0;
    chk_idle("rst_load");
    chk("rst_load_done", done, 0);

    q = {};
    for (int i = 0; i < DEPTH; i++)
      q.push_back(DW'($urandom) & 15'h3FFF);
    load(q, 1'b0);
    run(8'hFE, 0, 0, -1, -1, -1, 0, -1);
    run(0, 20, 10, -1, -1, -1, 0, 5);

    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(8, 40);
      q = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 99) < 15)
          q.push_back(15'h7800 | (DW'($urandom) & 15'h07FF));
        else
          q.push_back(DW'($urandom) & 15'h3FFF);
      end
      load(q, 1'b1);
      run($urandom_range(0, len - 1), 30, 10, -1, -1, -1, 0,
          ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
